// File: rtl/sys_defs.sv
// Shared processor definitions: width macros, the ROB entry layout seen by
// the retire stage, and the retire-stage state encoding.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define PR   6
`define XLEN 32
`define ROB  32
`endif

package sys_defs;

  localparam int PR_W      = `PR;
  localparam int XLEN_W    = `XLEN;
  localparam int ARCH_REGS = 32;

  typedef struct packed {
    logic              valid;
    logic              completed;
    logic              precise_state_need;
    logic              halt;
    logic [`XLEN-1:0]  target_pc;
    logic [4:0]        arch_reg;
    logic [`PR-1:0]    Tnew;
    logic [`PR-1:0]    Told;
  } ROB_ENTRY_PACKET;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } RETIRE_STATE;

endpackage

// File: rtl/retire_select.sv
// Combinational 3-way commit-mask generator. Way 2 is the oldest.
// Ports:
//   run          - stage is allowed to commit this cycle
//   valid, completed, precise, halt - per-way ROB head flags
//   retire_valid - contiguous commit mask starting at way 2
//   retire_num   - population count of retire_valid
//   recover_en   - youngest committed way is a mispredict (and not a halt)
//   recover_way  - index of that way
//   halt_commit  - a committed way carries halt
module retire_select (
  input  logic       run,
  input  logic [2:0] valid,
  input  logic [2:0] completed,
  input  logic [2:0] precise,
  input  logic [2:0] halt,
  output logic [2:0] retire_valid,
  output logic [1:0] retire_num,
  output logic       recover_en,
  output logic [1:0] recover_way,
  output logic       halt_commit
);

  logic blocked;

  // Any committed halt or mispredict blocks everything younger, so the
  // youngest committed way is the only one that can carry either flag.
  always_comb begin
    retire_valid = '0;
    retire_num   = '0;
    recover_en   = 1'b0;
    recover_way  = '0;
    halt_commit  = 1'b0;
    blocked      = ~run;
    for (int k = 2; k >= 0; k--) begin
      if (!blocked && valid[k] && completed[k]) begin
        retire_valid[k] = 1'b1;
        retire_num      = retire_num + 2'd1;
        if (halt[k]) begin
          halt_commit = 1'b1;
          blocked     = 1'b1;
        end else if (precise[k]) begin
          recover_en  = 1'b1;
          recover_way = 2'(k);
          blocked     = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_stage.sv
// In-order commit stage. Consumes the three ROB head entries each cycle,
// returns stale physical registers to the free list, updates the
// architectural map, raises branch recovery and latches halt.
// Ports:
//   clock, reset      - clock, synchronous active-low reset
//   rob_head_entry    - [2] is the ROB head (oldest)
//   retire_valid/num  - commit mask and count (combinational)
//   fl_free_valid/reg - Told returns to the free list (combinational)
//   BPRecoverEN       - flush request, target_pc the redirect address
//   archi_maptable    - registered architectural map
//   recover_maptable  - architectural map including this cycle's commits
//   halt, inst_count  - registered halt flag and retired count
//
// state  | meaning
// RUN    | committing normally
// HALTED | halt retired; no further commits until reset
module retire_stage
  import sys_defs::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  ROB_ENTRY_PACKET [2:0]       rob_head_entry,
  output logic [2:0]                  retire_valid,
  output logic [1:0]                  retire_num,
  output logic [2:0]                  fl_free_valid,
  output logic [2:0][`PR-1:0]         fl_free_reg,
  output logic                        BPRecoverEN,
  output logic [`XLEN-1:0]            target_pc,
  output logic [31:0][`PR-1:0]        archi_maptable,
  output logic [31:0][`PR-1:0]        recover_maptable,
  output logic                        halt,
  output logic [CNT_W-1:0]            inst_count
);

  RETIRE_STATE                        state;
  logic                               recover_en;
  logic [1:0]                         recover_way;
  logic                               halt_commit;
  logic [XLEN_W-1:0]                  pc_sel;
  logic [ARCH_REGS-1:0][PR_W-1:0]     map_next;

  retire_select u_select (
    .run          (state == RUN),
    .valid        ({rob_head_entry[2].valid, rob_head_entry[1].valid,
                    rob_head_entry[0].valid}),
    .completed    ({rob_head_entry[2].completed, rob_head_entry[1].completed,
                    rob_head_entry[0].completed}),
    .precise      ({rob_head_entry[2].precise_state_need,
                    rob_head_entry[1].precise_state_need,
                    rob_head_entry[0].precise_state_need}),
    .halt         ({rob_head_entry[2].halt, rob_head_entry[1].halt,
                    rob_head_entry[0].halt}),
    .retire_valid (retire_valid),
    .retire_num   (retire_num),
    .recover_en   (recover_en),
    .recover_way  (recover_way),
    .halt_commit  (halt_commit)
  );

  // Writes applied oldest first so the youngest writer of an arch reg wins.
  always_comb begin
    fl_free_valid = '0;
    fl_free_reg   = '0;
    map_next      = archi_maptable;
    for (int k = 2; k >= 0; k--) begin
      if (retire_valid[k] && (rob_head_entry[k].arch_reg != 5'd0)) begin
        fl_free_valid[k]                     = 1'b1;
        fl_free_reg[k]                       = rob_head_entry[k].Told;
        map_next[rob_head_entry[k].arch_reg] = rob_head_entry[k].Tnew;
      end
    end
  end

  always_comb begin
    case (recover_way)
      2'd2:    pc_sel = rob_head_entry[2].target_pc;
      2'd1:    pc_sel = rob_head_entry[1].target_pc;
      default: pc_sel = rob_head_entry[0].target_pc;
    endcase
  end

  assign recover_maptable = map_next;
  assign BPRecoverEN      = recover_en;
  assign target_pc        = recover_en ? pc_sel : '0;
  assign halt             = (state == HALTED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      inst_count <= '0;
      for (int i = 0; i < ARCH_REGS; i++) archi_maptable[i] <= PR_W'(i);
    end else begin
      archi_maptable <= map_next;
      inst_count     <= inst_count + CNT_W'(retire_num);
      if (state == RUN && halt_commit) state <= HALTED;
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
module tb_retire_stage;
  import sys_defs::*;

  logic                        clock;
  logic                        reset;
  ROB_ENTRY_PACKET [2:0]       ents;
  logic [2:0]                  retire_valid;
  logic [1:0]                  retire_num;
  logic [2:0]                  fl_free_valid;
  logic [2:0][PR_W-1:0]        fl_free_reg;
  logic                        BPRecoverEN;
  logic [XLEN_W-1:0]           target_pc;
  logic [31:0][PR_W-1:0]       archi_maptable;
  logic [31:0][PR_W-1:0]       recover_maptable;
  logic                        halt;
  logic [63:0]                 inst_count;

  typedef struct {
    string                tag;
    logic [2:0]           rv;
    logic [1:0]           num;
    logic [2:0]           ffv;
    logic [2:0][PR_W-1:0] ffr;
    logic                 bp;
    logic [XLEN_W-1:0]    tpc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  retire_stage #(.CNT_W(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .rob_head_entry   (ents),
    .retire_valid     (retire_valid),
    .retire_num       (retire_num),
    .fl_free_valid    (fl_free_valid),
    .fl_free_reg      (fl_free_reg),
    .BPRecoverEN      (BPRecoverEN),
    .target_pc        (target_pc),
    .archi_maptable   (archi_maptable),
    .recover_maptable (recover_maptable),
    .halt             (halt),
    .inst_count       (inst_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic ROB_ENTRY_PACKET mk(input logic v, input logic c,
                                         input logic p, input logic h,
                                         input int pc, input int a,
                                         input int tn, input int to);
    ROB_ENTRY_PACKET e;
    e.valid              = v;
    e.completed          = c;
    e.precise_state_need = p;
    e.halt               = h;
    e.target_pc          = XLEN_W'(pc);
    e.arch_reg           = 5'(a);
    e.Tnew               = PR_W'(tn);
    e.Told               = PR_W'(to);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] rv,
                      input logic [1:0] num, input logic [2:0] ffv,
                      input int r2, input int r1, input int r0,
                      input logic bp, input int tpc);
    exp_t e;
    e.tag    = tag;
    e.rv     = rv;
    e.num    = num;
    e.ffv    = ffv;
    e.ffr[2] = PR_W'(r2);
    e.ffr[1] = PR_W'(r1);
    e.ffr[0] = PR_W'(r0);
    e.bp     = bp;
    e.tpc    = XLEN_W'(tpc);
    q.push_back(e);
  endtask

  task automatic check_comb();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".rv"},  64'(retire_valid),  64'(e.rv));
      chk({e.tag, ".num"}, 64'(retire_num),    64'(e.num));
      chk({e.tag, ".ffv"}, 64'(fl_free_valid), 64'(e.ffv));
      chk({e.tag, ".ffr"}, 64'(fl_free_reg),   64'(e.ffr));
      chk({e.tag, ".bp"},  64'(BPRecoverEN),   64'(e.bp));
      chk({e.tag, ".pc"},  64'(target_pc),     64'(e.tpc));
    end
  endtask

  task automatic drive(input ROB_ENTRY_PACKET e2, input ROB_ENTRY_PACKET e1,
                       input ROB_ENTRY_PACKET e0);
    @(negedge clock);
    ents[2] = e2;
    ents[1] = e1;
    ents[0] = e0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  ROB_ENTRY_PACKET idle;

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    ents  = {idle, idle, idle};
    tick();
    tick();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst.count", inst_count, 64'd0);
    chk("rst.halt",  64'(halt), 64'd0);
    chk("rst.map7",  64'(archi_maptable[7]), 64'd7);
    chk("rst.map31", 64'(archi_maptable[31]), 64'd31);
    chk("rst.num",   64'(retire_num), 64'd0);

    // three ordinary commits
    drive(mk(1,1,0,0,0,1,32,1), mk(1,1,0,0,0,2,33,2), mk(1,1,0,0,0,3,34,3));
    push("all3", 3'b111, 2'd3, 3'b111, 1, 2, 3, 0, 0);
    #1; check_comb();
    chk("all3.rmap2", 64'(recover_maptable[2]), 64'd33);
    tick();
    chk("all3.map1", 64'(archi_maptable[1]), 64'd32);
    chk("all3.map2", 64'(archi_maptable[2]), 64'd33);
    chk("all3.map3", 64'(archi_maptable[3]), 64'd34);
    chk("all3.count", inst_count, 64'd3);

    // incomplete middle way stops the group
    drive(mk(1,1,0,0,0,4,35,4), mk(1,0,0,0,0,6,36,6), mk(1,1,0,0,0,7,37,7));
    push("gap", 3'b100, 2'd1, 3'b100, 4, 0, 0, 0, 0);
    #1; check_comb();
    tick();
    chk("gap.map4", 64'(archi_maptable[4]), 64'd35);
    chk("gap.map6", 64'(archi_maptable[6]), 64'd6);
    chk("gap.map7", 64'(archi_maptable[7]), 64'd7);
    chk("gap.count", inst_count, 64'd4);

    // mispredict in way 1 kills way 0
    drive(mk(1,1,0,0,0,8,38,8), mk(1,1,1,0,32,9,39,9), mk(1,1,0,0,0,10,40,10));
    push("bp", 3'b110, 2'd2, 3'b110, 8, 9, 0, 1, 32);
    #1; check_comb();
    chk("bp.rmap9",  64'(recover_maptable[9]), 64'd39);
    chk("bp.rmap10", 64'(recover_maptable[10]), 64'd10);
    tick();
    chk("bp.map10", 64'(archi_maptable[10]), 64'd10);
    chk("bp.count", inst_count, 64'd6);

    // same arch reg written twice, youngest wins
    drive(mk(1,1,0,0,0,5,40,5), mk(1,1,0,0,0,5,41,40), idle);
    push("waw", 3'b110, 2'd2, 3'b110, 5, 40, 0, 0, 0);
    #1; check_comb();
    chk("waw.rmap5", 64'(recover_maptable[5]), 64'd41);
    tick();
    chk("waw.map5", 64'(archi_maptable[5]), 64'd41);
    chk("waw.count", inst_count, 64'd8);

    // no destination: committed and counted, nothing freed
    drive(mk(1,1,0,0,0,0,42,0), idle, idle);
    push("nodst", 3'b100, 2'd1, 3'b000, 0, 0, 0, 0, 0);
    #1; check_comb();
    tick();
    chk("nodst.map0", 64'(archi_maptable[0]), 64'd0);
    chk("nodst.count", inst_count, 64'd9);

    // invalid head blocks younger completed ways
    drive(idle, mk(1,1,0,0,0,11,43,11), mk(1,1,0,0,0,12,44,12));
    push("nohead", 3'b000, 2'd0, 3'b000, 0, 0, 0, 0, 0);
    #1; check_comb();
    tick();
    chk("nohead.count", inst_count, 64'd9);
    chk("nohead.map11", 64'(archi_maptable[11]), 64'd11);

    // halt + mispredict on way 1: halt wins, no recovery
    drive(mk(1,1,0,0,0,12,44,12), mk(1,1,1,1,128,0,0,0), mk(1,1,0,0,0,13,45,13));
    push("halt", 3'b110, 2'd2, 3'b100, 12, 0, 0, 0, 0);
    #1; check_comb();
    chk("halt.pre", 64'(halt), 64'd0);
    tick();
    chk("halt.flag", 64'(halt), 64'd1);
    chk("halt.count", inst_count, 64'd11);
    chk("halt.map12", 64'(archi_maptable[12]), 64'd44);
    chk("halt.map13", 64'(archi_maptable[13]), 64'd13);

    // halted: nothing commits, mispredict suppressed
    drive(mk(1,1,1,0,64,14,46,14), mk(1,1,0,0,0,15,47,15), mk(1,1,0,0,0,16,48,16));
    push("halted", 3'b000, 2'd0, 3'b000, 0, 0, 0, 0, 0);
    #1; check_comb();
    tick();
    chk("halted.count", inst_count, 64'd11);
    chk("halted.map14", 64'(archi_maptable[14]), 64'd14);
    chk("halted.flag", 64'(halt), 64'd1);

    // reset while entries are still presented
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("rst2.map1", 64'(archi_maptable[1]), 64'd1);
    chk("rst2.map5", 64'(archi_maptable[5]), 64'd5);
    chk("rst2.count", inst_count, 64'd0);
    chk("rst2.halt", 64'(halt), 64'd0);

    // back in RUN: a mispredict on the head alone
    @(negedge clock);
    reset = 1'b1;
    ents[2] = mk(1,1,1,0,'h1234,17,49,17);
    ents[1] = mk(1,1,0,0,0,18,50,18);
    ents[0] = idle;
    push("bp2", 3'b100, 2'd1, 3'b100, 17, 0, 0, 1, 'h1234);
    #1; check_comb();
    tick();
    chk("bp2.map17", 64'(archi_maptable[17]), 64'd49);
    chk("bp2.map18", 64'(archi_maptable[18]), 64'd18);
    chk("bp2.count", inst_count, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- In-order commit end of the ROB protocol. Each cycle it consumes the three ROB head entries, way 2 oldest and way 0 youngest, and decides which of them commit.
- For each committed entry it returns the stale physical register (Told) to the free list and updates the architectural map table.
- On a committed mispredicted branch it raises BPRecoverEN with the redirect PC and kills younger commits. It latches a halt and counts retired instructions.
- Sits between ROB, free list, map table and fetch.

Parameters:
- CNT_W, 64, width of the retired-instruction counter.
- Widths come from the shared macros: `PR, `XLEN, `ROB.

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-low (0 = reset), sampled on posedge clock
- rob_head_entry  input  ROB_ENTRY_PACKET[2:0]  three oldest ROB entries; [2] is the head
- retire_valid  output  3  per-way commit this cycle (combinational)
- retire_num  output  2  number of committed entries, 0..3 (combinational)
- fl_free_valid  output  3  per-way Told return to the free list (combinational)
- fl_free_reg  output  [2:0][`PR-1:0]  Told per way (combinational)
- BPRecoverEN  output  1  flush/recover request (combinational)
- target_pc  output  `XLEN  redirect PC when BPRecoverEN=1, else 0 (combinational)
- archi_maptable  output  [31:0][`PR-1:0]  registered architectural map
- recover_maptable  output  [31:0][`PR-1:0]  architectural map including this cycle's commits (combinational)
- halt  output  1  registered; program finished
- inst_count  output  CNT_W  registered retired-instruction count

Behaviour:
- Reset (reset==0 at posedge):
  - archi_maptable[i]=i for i=0..31.
  - halt=0, inst_count=0, FSM=RUN.
  - Combinational outputs depend only on the inputs and this state.
  - Reset mid-operation overrides everything in that cycle.
- FSM has two states, RUN and HALTED.
  - RUN -> HALTED when a committed entry has halt=1.
  - HALTED is left only by reset.
  - In HALTED: retire_valid=0, BPRecoverEN=0, no state change except holding halt=1.
- Commit rule in RUN, evaluated way 2, then 1, then 0. Way k commits iff all of:
  - valid && completed;
  - every older way committed;
  - no older committed way has precise_state_need or halt.
- Commits are contiguous from way 2. No gaps: 3'b101 is illegal output.
- Destination handling:
  - An entry has a destination iff arch_reg != 0.
  - fl_free_valid[k] = retire_valid[k] && arch_reg != 0.
  - fl_free_reg[k] = Told, forced to 0 when fl_free_valid[k]=0.
- Map update: recover_maptable starts from archi_maptable and applies committed writes arch_reg <- Tnew in age order, way 2 first.
  - If several same-cycle commits write the same arch_reg, the youngest wins.
  - archi_maptable <= recover_maptable at posedge.
  - Entry 0 is never written.
- Recovery (zero-cycle latency):
  - BPRecoverEN=1 iff the youngest committed way has precise_state_need=1 and halt=0.
  - target_pc is that entry's target_pc.
  - Younger ways are not committed.
  - A branch entry with a destination still frees Told and updates the map.
- Halt:
  - The halt entry itself commits and is counted.
  - Younger ways are blocked.
  - An entry with both halt and precise_state_need: halt wins, BPRecoverEN=0.
  - halt goes to 1 at the next posedge.
- Counter: inst_count <= inst_count + retire_num, wrapping modulo 2^CNT_W.
- Invalid or incomplete head: retire_num=0 and all outputs idle; maps and counter hold.

Decomposition:
- sys_defs package (existing) already holds ROB_ENTRY_PACKET and `PR/`XLEN/`ROB.
- Add to it: a RETIRE_STATE enum {RUN, HALTED} and a localparam ARCH_REGS=32.
- One sub-module, retire_select: a purely combinational 3-way commit-mask generator that produces retire_valid, retire_num and the recovery way index.
- Map table, FSM and counter live in retire_stage.

Test Plan:
- Reset then three completed entries {arch 1/2/3, Tnew 32/33/34, Told 1/2/3} -> retire_num=3; fl_free_reg={1,2,3}; next cycle archi_maptable[1..3]={32,33,34}; inst_count=3.
- Way 2 completed, way 1 not completed, way 0 completed -> retire_valid=3'b100; only arch of way 2 is updated; inst_count+=1.
- Way 1 has precise_state_need=1, target_pc=32; ways 2 and 0 completed -> retire_valid=3'b110; BPRecoverEN=1; target_pc=32; recover_maptable includes way 2 and way 1 writes only.
- Ways 2 and 1 both write arch 5 (Tnew 40, 41) -> recover_maptable[5]=41; both Told freed.
- Way 2 has arch_reg=0, completed -> committed; fl_free_valid[2]=0; map unchanged; counted.
- Way 1 has halt=1 -> retire_valid=3'b110; halt=1 next cycle; later completed entries give retire_num=0 and inst_count stays frozen; reset low restores the identity map.
